mult_pipe: RTL and testbench

Parametrised, fully pipelined RV32M/RV64M multiplier with valid/ready handshakes on both sides, a destination tag carried alongside each operation, and a pipeline flush. It sits in the integer execute cluster behind the issue queue and in front of the writeback/CDB arbiter. It replaces the fixed-latency `mult` unit, which has no backpressure and no flush. Throughput is one operation per cycle when the consumer is ready.

---
 rtl/mult_pipe_if.sv | 35 +++
 rtl/mult_pipe.sv | 113 +++++++++++
 tb/tb_mult_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pipe_if.sv
// Handshake bundle between the issue side, mult_pipe and the writeback side.
// The slave modport is the multiplier's view; master is the surrounding cluster.
interface mult_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) ();

  // Issue side
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_type;
  logic [XLEN-1:0]  in1;
  logic [XLEN-1:0]  in2;
  logic [TAG_W-1:0] in_tag;

  // Pipeline control
  logic             flush;

  // Writeback side
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_type, in1, in2, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_type, in1, in2, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/mult_pipe.sv
// Fully pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU).
// Every stage holds a valid bit, the destination tag and the result. Stages
// advance independently so bubbles collapse under backpressure; a flush drops
// every in-flight operation including one presented in the same cycle.
// The product is formed in front of stage 0; the remaining stages give
// register retiming room to spread the multiplier array across the pipe.
module mult_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 5,
  parameter int TAG_W  = 6
) (
  input  logic       clock,
  input  logic       reset,
  mult_pipe_if.slave bus
);

  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } op_e;

  // Extends both operands to XLEN+1 bits (signedness by opcode), multiplies
  // them as signed values and picks the low or high half of the product.
  // Only the low 2*XLEN bits of the signed product are ever needed.
  function automatic logic [XLEN-1:0] f_mul(
    input op_e             op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic              a_sx;
    logic              b_sx;
    logic signed [XLEN:0] ea;
    logic signed [XLEN:0] eb;
    logic signed [PW-1:0] p;
    a_sx = (op == OP_MULH) || (op == OP_MULHSU);
    b_sx = (op == OP_MULH);
    ea   = {a_sx & a[XLEN-1], a};
    eb   = {b_sx & b[XLEN-1], b};
    p    = PW'(ea) * PW'(eb);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  // Stage registers
  logic [STAGES-1:0] r_vld;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [XLEN-1:0]   r_res [STAGES];

  // Per-stage load enables and load sources
  logic [STAGES-1:0] w_take;
  logic [STAGES-1:0] w_src_vld;
  logic [TAG_W-1:0]  w_src_tag [STAGES];
  logic [XLEN-1:0]   w_src_res [STAGES];
  logic [XLEN-1:0]   w_in_res;

  assign w_in_res = f_mul(op_e'(bus.in_type), bus.in1, bus.in2);

  // Stage i can load when it, or any stage after it, is empty, or when the
  // consumer is draining the last stage. Depends only on valid bits and
  // out_ready, never on in_valid.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_take
    assign w_take[gi] = bus.out_ready | ~(&r_vld[STAGES-1:gi]);
  end

  // Load source of each stage: the issue port for stage 0, the previous stage otherwise.
  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    w_src_vld    = '0;
    w_src_vld[0] = bus.in_valid;
    w_src_tag[0] = bus.in_tag;
    w_src_res[0] = w_in_res;
    for (int i = 1; i < STAGES; i++) begin
      w_src_vld[i] = r_vld[i-1];
      w_src_tag[i] = r_tag[i-1];
      w_src_res[i] = r_res[i-1];
    end
  end

  // Pipeline advance: flush clears every valid bit and overrides any load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: tag/result registers are reset as well so out_data and out_tag read
      // zero while reset is held; a flush only clears the valid bits.
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_tag[i] <= '0;
        r_res[i] <= '0;
      end
    end else if (bus.flush) begin
      r_vld <= '0;
    end else begin
      // NOTE: non-blocking updates let stage i read stage i-1's pre-edge value.
      for (int i = 0; i < STAGES; i++) begin
        if (w_take[i]) begin
          r_vld[i] <= w_src_vld[i];
          if (w_src_vld[i]) begin
            r_tag[i] <= w_src_tag[i];
            r_res[i] <= w_src_res[i];
          end
        end
      end
    end
  end

  assign bus.in_ready  = w_take[0];
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.out_data  = r_res[STAGES-1];
  assign bus.out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed ops, streaming, backpressure,
// flush, asynchronous reset and two parameter variants.
module tb_mult_pipe;

  localparam int ST = 5;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic clock;
  logic reset;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t q[$];

  mult_pipe_if #(.XLEN(32), .TAG_W(6)) bus   ();
  mult_pipe_if #(.XLEN(64), .TAG_W(6)) bus64 ();
  mult_pipe_if #(.XLEN(32), .TAG_W(6)) bus3  ();

  mult_pipe #(.XLEN(32), .STAGES(ST), .TAG_W(6)) u_dut   (.clock(clock), .reset(reset), .bus(bus));
  mult_pipe #(.XLEN(64), .STAGES(1),  .TAG_W(6)) u_dut64 (.clock(clock), .reset(reset), .bus(bus64));
  mult_pipe #(.XLEN(32), .STAGES(3),  .TAG_W(6)) u_dut3  (.clock(clock), .reset(reset), .bus(bus3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit two's-complement product of explicitly extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    sa = (t == 2'd1 || t == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    sb = (t == 2'd1)              ? {{32{b[31]}}, b} : {32'b0, b};
    p  = sa * sb;
    return (t == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tg);
    bus.in_valid = 1'b1;
    bus.in_type  = t;
    bus.in1      = a;
    bus.in2      = b;
    bus.in_tag   = tg;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Present one op until accepted; the expected result joins the scoreboard on acceptance.
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tg, input logic [31:0] ex);
    bit done = 1'b0;
    drive(t, a, b, tg);
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        q.push_back({tg, ex});
        done = 1'b1;
      end
      tick();
    end
    check("issue_accepted", done, 1);
  endtask

  // Cycles from the accepting edge until out_valid is first seen.
  task automatic latency(input int exp_lat, input string tag);
    int k    = 0;
    bit seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        seen = 1'b1;
        k    = n;
      end
      tick();
    end
    check(tag, k, exp_lat);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) tick();
    check("drain_empty", q.size(), 0);
  endtask

  // Scoreboard monitor: any visible result must match the head of the queue;
  // it is popped only when the transfer actually happens.
  always @(negedge clock) begin
    if (reset && bus.out_valid) begin
      if (q.size() == 0) begin
        check("spurious_result", bus.out_valid, 0);
      end else begin
        check("out_data", bus.out_data, q[0].data);
        check("out_tag",  bus.out_tag,  q[0].tag);
        if (bus.out_ready && !bus.flush) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] bp_a [7];
    logic [31:0] bp_b [7];
    int          acc;
    int          n0;
    int          k3;
    bit          seen3;

    reset = 1'b0;
    bus.in_valid   = 0; bus.in_type   = 0; bus.in1   = 0; bus.in2   = 0; bus.in_tag   = 0; bus.flush   = 0; bus.out_ready   = 1;
    bus64.in_valid = 0; bus64.in_type = 0; bus64.in1 = 0; bus64.in2 = 0; bus64.in_tag = 0; bus64.flush = 0; bus64.out_ready = 1;
    bus3.in_valid  = 0; bus3.in_type  = 0; bus3.in1  = 0; bus3.in2  = 0; bus3.in_tag  = 0; bus3.flush  = 0; bus3.out_ready  = 1;

    // Reset state
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_tag",   bus.out_tag,   0);
    check("rst64_out_valid", bus64.out_valid, 0);
    check("rst3_in_ready",   bus3.in_ready,   1);
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("rec_reset_in_ready", bus.in_ready, 1);
    tick();

    // Directed ops with exact latency on the first
    issue(2'd0, 32'd10, 32'd11, 6'd3, 32'd110);
    idle();
    latency(ST, "lat_mul");
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 6'd1, 32'h4000_0000);
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 32'hFFFF_FFFF);
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 32'hFFFF_FFFE);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 32'h0000_0001);
    idle();
    drain();

    // Streaming: 20 back-to-back ops, results in consecutive cycles 5..24
    for (int k = 0; k < 28; k++) begin
      if (k < 20) begin
        t = 2'(k % 4);
        a = $urandom;
        b = $urandom;
        drive(t, a, b, 6'(k));
      end else begin
        idle();
      end
      @(negedge clock);
      if (k < 20) begin
        check("stream_in_ready", bus.in_ready, 1);
        q.push_back({6'(k), ref_mul(t, a, b)});
      end
      check("stream_out_valid", bus.out_valid, (k >= 5 && k <= 24));
      tick();
    end
    drain();

    // Backpressure: only STAGES ops fit while out_ready is low
    for (int i = 0; i < 7; i++) begin
      bp_a[i] = $urandom;
      bp_b[i] = $urandom;
    end
    bus.out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      drive(2'(acc % 4), bp_a[acc], bp_b[acc], 6'(32 + acc));
      @(negedge clock);
      check("bp_in_ready", bus.in_ready, (cyc < 5));
      if (bus.in_ready) begin
        q.push_back({6'(32 + acc), ref_mul(2'(acc % 4), bp_a[acc], bp_b[acc])});
        acc++;
      end
      tick();
    end
    check("bp_accepted", acc, 5);
    @(negedge clock);
    check("bp_in_ready_full", bus.in_ready, 0);
    check("bp_out_valid_full", bus.out_valid, 1);
    tick();
    n0 = n_out;
    for (int cyc = 0; cyc < 80 && (acc < 7 || q.size() != 0); cyc++) begin
      bus.out_ready = cyc[0];
      if (acc < 7) drive(2'(acc % 4), bp_a[acc], bp_b[acc], 6'(32 + acc));
      else         idle();
      @(negedge clock);
      if (acc < 7 && bus.in_ready) begin
        q.push_back({6'(32 + acc), ref_mul(2'(acc % 4), bp_a[acc], bp_b[acc])});
        acc++;
      end
      tick();
    end
    check("bp_delivered", n_out - n0, 7);
    check("bp_queue_empty", q.size(), 0);
    bus.out_ready = 1'b1;
    idle();

    // Flush: three in flight plus one presented with flush are all dropped
    issue(2'd0, 32'd2, 32'd3, 6'd40, 32'd6);
    issue(2'd3, 32'd4, 32'd5, 6'd41, 32'd0);
    issue(2'd0, 32'd6, 32'd7, 6'd42, 32'd42);
    drive(2'd0, 32'd8, 32'd9, 6'd43);
    bus.flush = 1'b1;
    @(negedge clock);
    tick();
    bus.flush = 1'b0;
    idle();
    q.delete();
    @(negedge clock);
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_out_valid", bus.out_valid, 0);
    tick();
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      check("flush_no_result", bus.out_valid, 0);
      tick();
    end
    issue(2'd0, 32'd7, 32'd6, 6'd9, 32'd42);
    idle();
    latency(ST, "lat_after_flush");
    drain();

    // Asynchronous reset with four ops in flight
    bus.out_ready = 1'b0;
    issue(2'd0, 32'd11, 32'd12, 6'd50, 32'd132);
    issue(2'd1, 32'hFFFF_FFFF, 32'd5, 6'd51, 32'hFFFF_FFFF);
    issue(2'd2, 32'd3, 32'hFFFF_FFFF, 6'd52, 32'd2);
    issue(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 6'd53, ref_mul(2'd3, 32'h1234_5678, 32'h9ABC_DEF0));
    idle();
    tick();
    @(negedge clock);
    check("rst_mid_pre_valid", bus.out_valid, 1);
    tick();
    #3 reset = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_in_ready",  bus.in_ready,  1);
    check("rst_mid_out_data",  bus.out_data,  0);
    check("rst_mid_out_tag",   bus.out_tag,   0);
    q.delete();
    tick();
    #3 reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("rst_rel_in_ready", bus.in_ready, 1);
    tick();
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      check("rst_no_stale", bus.out_valid, 0);
      tick();
    end
    issue(2'd0, 32'd100, 32'd3, 6'd60, 32'd300);
    idle();
    drain();

    // XLEN=64, STAGES=1: MULHU of all-ones, result the next cycle
    bus64.in_valid = 1'b1;
    bus64.in_type  = 2'd3;
    bus64.in1      = 64'hFFFF_FFFF_FFFF_FFFF;
    bus64.in2      = 64'hFFFF_FFFF_FFFF_FFFF;
    bus64.in_tag   = 6'd7;
    @(negedge clock);
    check("x64_in_ready",  bus64.in_ready,  1);
    check("x64_pre_valid", bus64.out_valid, 0);
    tick();
    bus64.in_valid = 1'b0;
    @(negedge clock);
    check("x64_out_valid", bus64.out_valid, 1);
    check("x64_out_data",  bus64.out_data,  64'hFFFF_FFFF_FFFF_FFFE);
    check("x64_out_tag",   bus64.out_tag,   6'd7);
    tick();
    @(negedge clock);
    check("x64_drained", bus64.out_valid, 0);
    tick();

    // XLEN=32, STAGES=3: latency 3
    bus3.in_valid = 1'b1;
    bus3.in_type  = 2'd0;
    bus3.in1      = 32'd10;
    bus3.in2      = 32'd11;
    bus3.in_tag   = 6'd5;
    @(negedge clock);
    check("s3_in_ready", bus3.in_ready, 1);
    tick();
    bus3.in_valid = 1'b0;
    k3    = 0;
    seen3 = 1'b0;
    for (int n = 1; n <= 10 && !seen3; n++) begin
      @(negedge clock);
      if (bus3.out_valid) begin
        seen3 = 1'b1;
        k3    = n;
        check("s3_out_data", bus3.out_data, 32'd110);
        check("s3_out_tag",  bus3.out_tag,  6'd5);
      end
      tick();
    end
    check("s3_latency", k3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
